mc_controller: RTL and testbench

- Multicycle control FSM for the MIPS core. Replaces the single-cycle controller when the datapath is rebuilt around a unified instruction/data memory.
- Sequences fetch, decode, execute, memory and writeback over several cycles and drives the register enables and multiplexer selects.
- Stalls in any memory state until the memory reports ready.
- Sits between the instruction register's opcode/funct fields and the multicycle datapath, inside the mips top level.

---
 rtl/mc_pkg.sv | 70 +++++++
 rtl/mc_if.sv | 36 +++
 rtl/mc_aludec.sv | 33 +++
 rtl/mc_controller.sv | 158 +++++++++++++++
 tb/tb_mc_controller.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/mc_pkg.sv
// mc_pkg: shared encodings for the multicycle MIPS controller.
// Holds opcode/funct codes, the FSM state enum, the ALU-op class and the
// alucontrol / alusrcb / pcsrc select encodings.
// Optional feature macro MC_BNE_EN adds the BNEEX state.
package mc_pkg;

    localparam int unsigned OP_W    = 6;
    localparam int unsigned FUNCT_W = 6;
    localparam int unsigned ALUC_W  = 3;
    localparam int unsigned SEL_W   = 2;

    // Opcodes (instr[31:26])
    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_J     = 6'b000010;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_BNE   = 6'b000101;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;

    // R-type funct codes (instr[5:0])
    localparam logic [FUNCT_W-1:0] F_ADD = 6'b100000;
    localparam logic [FUNCT_W-1:0] F_SUB = 6'b100010;
    localparam logic [FUNCT_W-1:0] F_AND = 6'b100100;
    localparam logic [FUNCT_W-1:0] F_OR  = 6'b100101;
    localparam logic [FUNCT_W-1:0] F_SLT = 6'b101010;

    // ALU control encodings
    localparam logic [ALUC_W-1:0] ALUC_ADD = 3'b010;
    localparam logic [ALUC_W-1:0] ALUC_SUB = 3'b110;
    localparam logic [ALUC_W-1:0] ALUC_AND = 3'b000;
    localparam logic [ALUC_W-1:0] ALUC_OR  = 3'b001;
    localparam logic [ALUC_W-1:0] ALUC_SLT = 3'b111;

    // ALU B operand select
    localparam logic [SEL_W-1:0] ALUB_B     = 2'b00;
    localparam logic [SEL_W-1:0] ALUB_FOUR  = 2'b01;
    localparam logic [SEL_W-1:0] ALUB_IMM   = 2'b10;
    localparam logic [SEL_W-1:0] ALUB_IMMSH = 2'b11;

    // Next-PC select
    localparam logic [SEL_W-1:0] PC_ALURES = 2'b00;
    localparam logic [SEL_W-1:0] PC_ALUOUT = 2'b01;
    localparam logic [SEL_W-1:0] PC_JUMP   = 2'b10;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } aluop_t;

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        RTYPEEX = 4'd6,
        RTYPEWB = 4'd7,
        BEQEX   = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
        JEX     = 4'd11
`ifdef MC_BNE_EN
        , BNEEX = 4'd12
`endif
    } state_t;

endpackage

// File: rtl/mc_if.sv
// mc_if: instruction-field/status inputs and control outputs between the
// multicycle controller (master) and the datapath (slave).
interface mc_if;
    import mc_pkg::*;

    logic [OP_W-1:0]    op;
    logic [FUNCT_W-1:0] funct;
    logic               zero;
    logic               memready;

    logic               iord;
    logic               memwrite;
    logic               irwrite;
    logic               regdst;
    logic               memtoreg;
    logic               regwrite;
    logic               alusrca;
    logic [SEL_W-1:0]   alusrcb;
    logic [SEL_W-1:0]   pcsrc;
    logic               pcen;
    logic [ALUC_W-1:0]  alucontrol;
    logic               illegal_op;

    modport master (
        input  op, funct, zero, memready,
        output iord, memwrite, irwrite, regdst, memtoreg, regwrite,
               alusrca, alusrcb, pcsrc, pcen, alucontrol, illegal_op
    );

    modport slave (
        output op, funct, zero, memready,
        input  iord, memwrite, irwrite, regdst, memtoreg, regwrite,
               alusrca, alusrcb, pcsrc, pcen, alucontrol, illegal_op
    );

endinterface

// File: rtl/mc_aludec.sv
// mc_aludec: combinational ALU decoder.
// Ports: aluop (class from FSM), funct (instr[5:0]) -> alucontrol,
//        bad_funct (set only for an unknown funct in the funct class).
module mc_aludec
    import mc_pkg::*;
(
    input  aluop_t             aluop,
    input  logic [FUNCT_W-1:0] funct,
    output logic [ALUC_W-1:0]  alucontrol,
    output logic               bad_funct
);

    always_comb begin
        alucontrol = ALUC_ADD;
        bad_funct  = 1'b0;
        case (aluop)
            ALUOP_SUB: alucontrol = ALUC_SUB;
            ALUOP_FUNCT: begin
                case (funct)
                    F_ADD:   alucontrol = ALUC_ADD;
                    F_SUB:   alucontrol = ALUC_SUB;
                    F_AND:   alucontrol = ALUC_AND;
                    F_OR:    alucontrol = ALUC_OR;
                    F_SLT:   alucontrol = ALUC_SLT;
                    // unknown funct still adds so the writeback is harmless
                    default: bad_funct  = 1'b1;
                endcase
            end
            default: alucontrol = ALUC_ADD;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// mc_controller: multicycle MIPS control FSM (fetch/decode/execute/mem/wb).
// Ports: clk, reset (synchronous, active-high), bus (mc_if.master):
//   inputs op, funct, zero, memready; outputs register enables, mux selects,
//   alucontrol and the illegal_op pulse.
// Parameter USE_MEM_READY: 1 = memory states wait on memready, 0 = ignore it.
// Macro MC_BNE_EN: adds bne decode and the BNEEX state.
// Selects are decoded from state; strobes in memory states follow memready
// in the same cycle, and every strobe is forced low while reset is high.
module mc_controller
    import mc_pkg::*;
#(
    parameter bit USE_MEM_READY = 1'b1
)
(
    input  logic     clk,
    input  logic     reset,
    mc_if.master     bus
);

    state_t state;
    state_t state_next;
    aluop_t aluop;
    logic   mem_rdy;
    logic   op_bad;
    logic   bad_funct;
    logic   irwrite_s, pcen_s, memwrite_s, regwrite_s, illegal_s;

    assign mem_rdy = USE_MEM_READY ? bus.memready : 1'b1;

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= FETCH;
        else       state <= state_next;
    end

    // Next-state logic; also flags opcodes DECODE cannot dispatch
    always_comb begin
        state_next = FETCH;
        op_bad     = 1'b0;
        case (state)
            FETCH:  state_next = mem_rdy ? DECODE : FETCH;
            DECODE: begin
                case (bus.op)
                    OP_LW, OP_SW: state_next = MEMADR;
                    OP_RTYPE:     state_next = RTYPEEX;
                    OP_BEQ:       state_next = BEQEX;
`ifdef MC_BNE_EN
                    OP_BNE:       state_next = BNEEX;
`endif
                    OP_ADDI:      state_next = ADDIEX;
                    OP_J:         state_next = JEX;
                    default: begin
                        state_next = FETCH;
                        op_bad     = 1'b1;
                    end
                endcase
            end
            MEMADR: begin
                if (bus.op == OP_LW)      state_next = MEMRD;
                else if (bus.op == OP_SW) state_next = MEMWR;
                else                      state_next = FETCH;
            end
            MEMRD:   state_next = mem_rdy ? MEMWB : MEMRD;
            MEMWR:   state_next = mem_rdy ? FETCH : MEMWR;
            RTYPEEX: state_next = RTYPEWB;
            ADDIEX:  state_next = ADDIWB;
            default: state_next = FETCH;
        endcase
    end

    // Output decode
    always_comb begin
        bus.iord     = 1'b0;
        bus.regdst   = 1'b0;
        bus.memtoreg = 1'b0;
        bus.alusrca  = 1'b0;
        bus.alusrcb  = ALUB_B;
        bus.pcsrc    = PC_ALURES;
        aluop        = ALUOP_ADD;
        irwrite_s    = 1'b0;
        pcen_s       = 1'b0;
        memwrite_s   = 1'b0;
        regwrite_s   = 1'b0;
        illegal_s    = 1'b0;
        case (state)
            FETCH: begin
                bus.alusrcb = ALUB_FOUR;
                irwrite_s   = mem_rdy;
                pcen_s      = mem_rdy;
            end
            DECODE: begin
                bus.alusrcb = ALUB_IMMSH;
                illegal_s   = op_bad;
            end
            MEMADR: begin
                bus.alusrca = 1'b1;
                bus.alusrcb = ALUB_IMM;
            end
            MEMRD: bus.iord = 1'b1;
            MEMWB: begin
                bus.memtoreg = 1'b1;
                regwrite_s   = 1'b1;
            end
            MEMWR: begin
                bus.iord   = 1'b1;
                memwrite_s = mem_rdy;
            end
            RTYPEEX: begin
                bus.alusrca = 1'b1;
                aluop       = ALUOP_FUNCT;
                illegal_s   = bad_funct;
            end
            RTYPEWB: begin
                bus.regdst = 1'b1;
                regwrite_s = 1'b1;
            end
            BEQEX: begin
                bus.alusrca = 1'b1;
                aluop       = ALUOP_SUB;
                bus.pcsrc   = PC_ALUOUT;
                pcen_s      = bus.zero;
            end
`ifdef MC_BNE_EN
            BNEEX: begin
                bus.alusrca = 1'b1;
                aluop       = ALUOP_SUB;
                bus.pcsrc   = PC_ALUOUT;
                pcen_s      = ~bus.zero;
            end
`endif
            ADDIEX: begin
                bus.alusrca = 1'b1;
                bus.alusrcb = ALUB_IMM;
            end
            ADDIWB: regwrite_s = 1'b1;
            JEX: begin
                bus.pcsrc = PC_JUMP;
                pcen_s    = 1'b1;
            end
            default: ;
        endcase
    end

    // Reset suppresses every strobe, so an abandoned instruction writes nothing
    assign bus.irwrite    = irwrite_s  & ~reset;
    assign bus.pcen       = pcen_s     & ~reset;
    assign bus.memwrite   = memwrite_s & ~reset;
    assign bus.regwrite   = regwrite_s & ~reset;
    assign bus.illegal_op = illegal_s  & ~reset;

    mc_aludec u_aludec (
        .aluop      (aluop),
        .funct      (bus.funct),
        .alucontrol (bus.alucontrol),
        .bad_funct  (bad_funct)
    );

endmodule

// File: tb/tb_mc_controller.sv
// tb_mc_controller: table-driven cycle vectors for mc_controller plus
// hand sequences for instruction cycle counts and reset inside MEMWR.
module tb_mc_controller;
    import mc_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mc_if bus ();

    mc_controller #(.USE_MEM_READY(1'b1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Control word: iord mw irw regdst memtoreg regwrite alusrca alusrcb[2] pcsrc[2] pcen aluc[3] ill
    typedef struct {
        logic        rst;
        logic [5:0]  op;
        logic [5:0]  funct;
        logic        zero;
        logic        mr;
        state_t      st;
        logic [15:0] ctl;
        logic [15:0] mask;
    } vec_t;

    vec_t vecs[$];
    int   total = 0;
    int   bad   = 0;

    localparam logic [15:0] MA = 16'hFFFF;
    localparam logic [15:0] MN = 16'hFFF1;   // ignore alucontrol

    function automatic logic [15:0] mk(input logic iord, input logic mw, input logic irw,
                                       input logic rd, input logic mtr, input logic rw,
                                       input logic asa, input logic [1:0] asb,
                                       input logic [1:0] pcs, input logic pcen,
                                       input logic [2:0] alu, input logic ill);
        return {iord, mw, irw, rd, mtr, rw, asa, asb, pcs, pcen, alu, ill};
    endfunction

    function automatic logic [15:0] act();
        return {bus.iord, bus.memwrite, bus.irwrite, bus.regdst, bus.memtoreg,
                bus.regwrite, bus.alusrca, bus.alusrcb, bus.pcsrc, bus.pcen,
                bus.alucontrol, bus.illegal_op};
    endfunction

    task automatic add(input logic rst, input logic [5:0] op, input logic [5:0] funct,
                       input logic zero, input logic mr, input state_t st,
                       input logic [15:0] ctl, input logic [15:0] mask);
        vec_t v;
        v.rst = rst; v.op = op; v.funct = funct; v.zero = zero; v.mr = mr;
        v.st = st; v.ctl = ctl; v.mask = mask;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic rst, input logic [5:0] op, input logic [5:0] funct,
                         input logic zero, input logic mr);
        reset        = rst;
        bus.op       = op;
        bus.funct    = funct;
        bus.zero     = zero;
        bus.memready = mr;
    endtask

    task automatic chk1(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    // Runs one instruction from FETCH with memready=1 and counts edges back to FETCH
    task automatic count_cycles(input logic [5:0] op, input int expn, input string name);
        int n = 0;
        drive(1'b0, op, 6'd0, 1'b0, 1'b1);
        do begin
            @(negedge clk); #1;
            n++;
        end while (dut.state != FETCH && n < 20);
        bus.memready = 1'b0;
        chk1(name, 32'(n), 32'(expn));
    endtask

    logic [15:0] c_fetch, c_fetch_st, c_dec, c_dec_ill, c_memadr, c_memrd, c_memwb;
    logic [15:0] c_memwr_w, c_memwr, c_rex_slt, c_rex_bad, c_rwb, c_beq_t, c_beq_f;
    logic [15:0] c_addiex, c_addiwb, c_jex;

    initial begin
        c_fetch    = mk(0,0,1,0,0,0,0,2'b01,2'b00,1,3'b010,0);
        c_fetch_st = mk(0,0,0,0,0,0,0,2'b01,2'b00,0,3'b010,0);
        c_dec      = mk(0,0,0,0,0,0,0,2'b11,2'b00,0,3'b010,0);
        c_dec_ill  = mk(0,0,0,0,0,0,0,2'b11,2'b00,0,3'b010,1);
        c_memadr   = mk(0,0,0,0,0,0,1,2'b10,2'b00,0,3'b010,0);
        c_memrd    = mk(1,0,0,0,0,0,0,2'b00,2'b00,0,3'b000,0);
        c_memwb    = mk(0,0,0,0,1,1,0,2'b00,2'b00,0,3'b000,0);
        c_memwr_w  = mk(1,0,0,0,0,0,0,2'b00,2'b00,0,3'b000,0);
        c_memwr    = mk(1,1,0,0,0,0,0,2'b00,2'b00,0,3'b000,0);
        c_rex_slt  = mk(0,0,0,0,0,0,1,2'b00,2'b00,0,3'b111,0);
        c_rex_bad  = mk(0,0,0,0,0,0,1,2'b00,2'b00,0,3'b010,1);
        c_rwb      = mk(0,0,0,1,0,1,0,2'b00,2'b00,0,3'b000,0);
        c_beq_t    = mk(0,0,0,0,0,0,1,2'b00,2'b01,1,3'b110,0);
        c_beq_f    = mk(0,0,0,0,0,0,1,2'b00,2'b01,0,3'b110,0);
        c_addiex   = mk(0,0,0,0,0,0,1,2'b10,2'b00,0,3'b010,0);
        c_addiwb   = mk(0,0,0,0,0,1,0,2'b00,2'b00,0,3'b000,0);
        c_jex      = mk(0,0,0,0,0,0,0,2'b00,2'b10,1,3'b000,0);

        // reset, then lw with one MEMRD stall
        add(1, OP_LW,    6'd0,  0, 1, FETCH,   c_fetch_st, MA);
        add(0, OP_LW,    6'd0,  0, 1, FETCH,   c_fetch,    MA);
        add(0, OP_LW,    6'd0,  0, 1, DECODE,  c_dec,      MA);
        add(0, OP_LW,    6'd0,  0, 1, MEMADR,  c_memadr,   MA);
        add(0, OP_LW,    6'd0,  0, 0, MEMRD,   c_memrd,    MN);
        add(0, OP_LW,    6'd0,  0, 1, MEMRD,   c_memrd,    MN);
        add(0, OP_LW,    6'd0,  0, 1, MEMWB,   c_memwb,    MN);
        // sw: one FETCH stall, three MEMWR stalls
        add(0, OP_SW,    6'd0,  0, 0, FETCH,   c_fetch_st, MA);
        add(0, OP_SW,    6'd0,  0, 1, FETCH,   c_fetch,    MA);
        add(0, OP_SW,    6'd0,  0, 1, DECODE,  c_dec,      MA);
        add(0, OP_SW,    6'd0,  0, 1, MEMADR,  c_memadr,   MA);
        add(0, OP_SW,    6'd0,  0, 0, MEMWR,   c_memwr_w,  MN);
        add(0, OP_SW,    6'd0,  0, 0, MEMWR,   c_memwr_w,  MN);
        add(0, OP_SW,    6'd0,  0, 0, MEMWR,   c_memwr_w,  MN);
        add(0, OP_SW,    6'd0,  0, 1, MEMWR,   c_memwr,    MN);
        // beq taken / not taken
        add(0, OP_BEQ,   6'd0,  1, 1, FETCH,   c_fetch,    MA);
        add(0, OP_BEQ,   6'd0,  1, 1, DECODE,  c_dec,      MA);
        add(0, OP_BEQ,   6'd0,  1, 1, BEQEX,   c_beq_t,    MA);
        add(0, OP_BEQ,   6'd0,  0, 1, FETCH,   c_fetch,    MA);
        add(0, OP_BEQ,   6'd0,  0, 1, DECODE,  c_dec,      MA);
        add(0, OP_BEQ,   6'd0,  0, 1, BEQEX,   c_beq_f,    MA);
        // R-type slt, then unknown funct
        add(0, OP_RTYPE, F_SLT, 0, 1, FETCH,   c_fetch,    MA);
        add(0, OP_RTYPE, F_SLT, 0, 1, DECODE,  c_dec,      MA);
        add(0, OP_RTYPE, F_SLT, 0, 1, RTYPEEX, c_rex_slt,  MA);
        add(0, OP_RTYPE, F_SLT, 0, 1, RTYPEWB, c_rwb,      MN);
        add(0, OP_RTYPE, 6'h07, 0, 1, FETCH,   c_fetch,    MA);
        add(0, OP_RTYPE, 6'h07, 0, 1, DECODE,  c_dec,      MA);
        add(0, OP_RTYPE, 6'h07, 0, 1, RTYPEEX, c_rex_bad,  MA);
        add(0, OP_RTYPE, 6'h07, 0, 1, RTYPEWB, c_rwb,      MN);
        // addi, j
        add(0, OP_ADDI,  6'd0,  0, 1, FETCH,   c_fetch,    MA);
        add(0, OP_ADDI,  6'd0,  0, 1, DECODE,  c_dec,      MA);
        add(0, OP_ADDI,  6'd0,  0, 1, ADDIEX,  c_addiex,   MA);
        add(0, OP_ADDI,  6'd0,  0, 1, ADDIWB,  c_addiwb,   MN);
        add(0, OP_J,     6'd0,  0, 1, FETCH,   c_fetch,    MA);
        add(0, OP_J,     6'd0,  0, 1, DECODE,  c_dec,      MA);
        add(0, OP_J,     6'd0,  0, 1, JEX,     c_jex,      MN);
        // unsupported opcode
        add(0, 6'h3f,    6'd0,  0, 1, FETCH,   c_fetch,    MA);
        add(0, 6'h3f,    6'd0,  0, 1, DECODE,  c_dec_ill,  MA);
        // bne
        add(0, OP_BNE,   6'd0,  0, 1, FETCH,   c_fetch,    MA);
`ifdef MC_BNE_EN
        add(0, OP_BNE,   6'd0,  0, 1, DECODE,  c_dec,      MA);
        add(0, OP_BNE,   6'd0,  0, 1, BNEEX,   c_beq_t,    MA);
`else
        add(0, OP_BNE,   6'd0,  0, 1, DECODE,  c_dec_ill,  MA);
`endif
        // park in FETCH
        add(0, OP_LW,    6'd0,  0, 0, FETCH,   c_fetch_st, MA);

        drive(1'b1, OP_LW, 6'd0, 1'b0, 1'b1);
        @(negedge clk);
        @(negedge clk);

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].rst, vecs[i].op, vecs[i].funct, vecs[i].zero, vecs[i].mr);
            #1;
            total++;
            if (dut.state !== vecs[i].st) begin
                bad++;
                $display("FAIL vec%0d state: got %0d want %0d", i, dut.state, vecs[i].st);
            end
            total++;
            if ((act() & vecs[i].mask) !== (vecs[i].ctl & vecs[i].mask)) begin
                bad++;
                $display("FAIL vec%0d ctl: got %04h want %04h (mask %04h)",
                         i, act() & vecs[i].mask, vecs[i].ctl, vecs[i].mask);
            end
        end

        count_cycles(OP_LW,   5, "cycles_lw");
        count_cycles(OP_ADDI, 4, "cycles_addi");
        count_cycles(OP_J,    3, "cycles_j");

        // reset asserted while sitting in MEMWR with memready=1
        begin
            int n = 0;
            drive(1'b0, OP_SW, 6'd0, 1'b0, 1'b1);
            do begin
                @(negedge clk); #1;
                n++;
            end while (dut.state != MEMWR && n < 10);
            if (dut.state != MEMWR) begin
                total++;
                bad++;
                $display("FAIL rst_memwr_reach: got state %0d want %0d", dut.state, MEMWR);
            end else begin
                reset = 1'b1;
                #1;
                chk1("rst_memwr_memwrite", 32'(bus.memwrite), 32'd0);
                chk1("rst_memwr_regwrite", 32'(bus.regwrite), 32'd0);
                @(negedge clk); #1;
                chk1("rst_memwr_state", 32'(dut.state), 32'(FETCH));
                chk1("rst_memwr_irwrite", 32'(bus.irwrite), 32'd0);
                chk1("rst_memwr_pcen", 32'(bus.pcen), 32'd0);
            end
            drive(1'b0, OP_SW, 6'd0, 1'b0, 1'b0);
        end

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
